// File: rtl/lsu_align_unit.sv
// lsu_align_unit
// MEM-stage load/store alignment in front of a byte-enabled, word-indexed data
// BRAM with combinational read. Turns RV32I loads/stores into lane enables,
// lane-rotated write data and word addresses, and extends load results.
// An access that crosses a word boundary takes two BRAM cycles: the first half
// stalls the pipeline and parks the low word in lo_buf, the second completes.
// Optional build macro: LSU_SPLIT_CNT_EN adds a wrapping count of split accesses
// on split_cnt; without it split_cnt is tied to zero.
module lsu_align_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  split_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [1:0]        k_s;
    logic [4:0]        sh_s;
    logic [5:0]        sh_inv_s;
    logic [3:0]        size_mask_s;
    logic              illegal_s;
    logic              split_raw_s;
    logic              split_s;
    logic [7:0]        lane_wide_s;
    logic [3:0]        lane_lo_s;
    logic [3:0]        lane_hi_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [ADDR_W-1:0] word_addr_nxt_s;
    logic [31:0]       wdata_rot_s;
    logic [63:0]       window_s;
    logic [31:0]       load_win_s;
    logic [31:0]       load_ext_s;
    logic [31:0]       lo_buf_r;
    logic              enter_second_s;

    // Byte offset within the word and the matching bit shift amounts.
    assign k_s      = req_addr[1:0];
    assign sh_s     = {k_s, 3'b000};
    assign sh_inv_s = 6'd32 - {1'b0, sh_s};

    // Word addresses of the first half and of the following word (wraps naturally).
    assign word_addr_s     = {req_addr[ADDR_W-1:2], 2'b00};
    assign word_addr_nxt_s = word_addr_s + ADDR_W'(4);

    // Store data rotated left by 8*k so each byte lands on its BRAM lane in either phase.
    assign wdata_rot_s = 32'({req_wdata, req_wdata} >> sh_inv_s);

    // Lane mask spread over two words: low nibble is the first word, high nibble the next.
    assign lane_wide_s = {4'b0000, size_mask_s} << k_s;
    assign lane_lo_s   = lane_wide_s[3:0];
    assign lane_hi_s   = lane_wide_s[7:4];

    // Size decode, illegal funct3 detection and word-crossing detection.
    always_comb begin
        size_mask_s = 4'b0000;
        split_raw_s = 1'b0;
        case (req_funct3[1:0])
            2'b00: begin
                size_mask_s = 4'b0001;
                split_raw_s = 1'b0;
            end
            2'b01: begin
                size_mask_s = 4'b0011;
                split_raw_s = (k_s == 2'b11);
            end
            2'b10: begin
                size_mask_s = 4'b1111;
                split_raw_s = (k_s != 2'b00);
            end
            default: begin
                size_mask_s = 4'b0000;
                split_raw_s = 1'b0;
            end
        endcase
        illegal_s = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        split_s   = split_raw_s && !illegal_s;
    end

    // Load window: the current word alone, or the next word on top of the parked low word.
    always_comb begin
        window_s = 64'h0;
        if (state_r == ST_SECOND) begin
            window_s = {mem_rdata, lo_buf_r};
        end else begin
            window_s = {32'h0, mem_rdata};
        end
    end

    assign load_win_s = 32'(window_s >> sh_s);

    // Keep the low size bytes of the shifted window and sign- or zero-extend them.
    always_comb begin
        load_ext_s = 32'h0;
        case (req_funct3[1:0])
            2'b00: load_ext_s = req_funct3[2] ? {24'h0, load_win_s[7:0]}
                                              : {{24{load_win_s[7]}}, load_win_s[7:0]};
            2'b01: load_ext_s = req_funct3[2] ? {16'h0, load_win_s[15:0]}
                                              : {{16{load_win_s[15]}}, load_win_s[15:0]};
            2'b10: load_ext_s = load_win_s;
            default: load_ext_s = 32'h0;
        endcase
    end

    // FSM next state and all BRAM/pipeline outputs; everything forced quiet in reset.
    always_comb begin
        state_nxt_s = state_r;
        stall       = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = 32'h0;
        mem_we      = 4'b0000;
        mem_addr    = word_addr_s;
        mem_wdata   = wdata_rot_s;
        if (!rst_n) begin
            state_nxt_s = ST_IDLE;
            mem_addr    = '0;
            mem_wdata   = 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!req_valid) begin
                        state_nxt_s = ST_IDLE;
                    end else if (illegal_s) begin
                        rsp_valid = 1'b1;
                    end else if (split_s) begin
                        stall       = 1'b1;
                        mem_we      = req_we ? lane_lo_s : 4'b0000;
                        state_nxt_s = ST_SECOND;
                    end else begin
                        mem_we    = req_we ? lane_lo_s : 4'b0000;
                        rsp_valid = 1'b1;
                        rsp_rdata = req_we ? 32'h0 : load_ext_s;
                    end
                end
                ST_SECOND: begin
                    // Request withdrawn means abort: no second access, no response.
                    if (req_valid) begin
                        mem_addr  = word_addr_nxt_s;
                        mem_we    = req_we ? lane_hi_s : 4'b0000;
                        rsp_valid = 1'b1;
                        rsp_rdata = req_we ? 32'h0 : load_ext_s;
                    end else begin
                        mem_we = 4'b0000;
                    end
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    assign enter_second_s = (state_r == ST_IDLE) && (state_nxt_s == ST_SECOND);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Park the first-half read word when a split access starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_buf_r <= 32'h0;
        end else if (enter_second_s) begin
            lo_buf_r <= mem_rdata;
        end else begin
            lo_buf_r <= lo_buf_r;
        end
    end

`ifdef LSU_SPLIT_CNT_EN
    logic [CNT_W-1:0] split_cnt_r;

    // Count every transition into the second phase; wraps at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt_r <= '0;
        end else if (enter_second_s) begin
            split_cnt_r <= split_cnt_r + CNT_W'(1);
        end else begin
            split_cnt_r <= split_cnt_r;
        end
    end

    assign split_cnt = split_cnt_r;
`else
    assign split_cnt = '0;
`endif

endmodule

// File: tb/tb_lsu_align_unit.sv
// tb_lsu_align_unit
// Directed and random load/store traffic against lsu_align_unit driving a
// behavioural BRAM. Expected values come from a byte-addressed memory model.
// Honours LSU_SPLIT_CNT_EN for the split counter expectation.
module tb_lsu_align_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] split_cnt;

    logic [31:0] bram [0:16383];
    logic        pre_en;
    logic [13:0] pre_idx;
    logic [31:0] pre_word;

    logic [7:0]  ref_bytes [0:65535];
    int          exp_splits;
    int          n_checks;
    int          n_pass;
    int          n_fail;

    lsu_align_unit #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .split_cnt  (split_cnt)
    );

    always #5 clk = ~clk;

    assign mem_rdata = bram[mem_addr[15:2]];

    // BRAM: preload port during bench setup, byte-enabled writes from the DUT otherwise.
    always @(posedge clk) begin
        if (pre_en) begin
            bram[pre_idx] <= pre_word;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) bram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic bit is_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Reference load: gather bytes from the byte memory, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        logic [15:0] idx;
        int          sz;
        v  = 32'h0;
        sz = size_of(f3);
        for (int i = 0; i < sz; i++) begin
            idx = 16'(addr + 32'(i));
            v   = v | (32'(ref_bytes[idx]) << (8 * i));
        end
        if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic preload(input int widx, input logic [31:0] w);
        pre_en   = 1'b1;
        pre_idx  = 14'(widx);
        pre_word = w;
        for (int b = 0; b < 4; b++) ref_bytes[16'(widx * 4 + b)] = w[8*b +: 8];
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // One complete access starting just after a rising edge; returns observed rsp_rdata.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd_obs);
        int          sz;
        int          k;
        bit          legal;
        bit          spl;
        logic [3:0]  we1;
        logic [3:0]  we2;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [31:0] a0;
        legal  = is_legal(f3);
        sz     = size_of(f3);
        k      = int'(addr[1:0]);
        spl    = legal && (k + sz > 4);
        we1    = 4'b0000;
        we2    = 4'b0000;
        exp_wd = 32'h0;
        if (legal && we) begin
            for (int i = 0; i < sz; i++) begin
                if (k + i < 4) we1[k + i] = 1'b1;
                else           we2[k + i - 4] = 1'b1;
            end
        end
        for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*((l - k + 4) % 4) +: 8];
        exp_rd = (legal && !we) ? model_load(f3, addr) : 32'h0;
        a0     = {addr[31:2], 2'b00};

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        if (spl) begin
            chk("p1_stall", 32'(stall), 32'd1);
            chk("p1_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("p1_addr", mem_addr, a0);
            chk("p1_we", 32'(mem_we), 32'(we1));
            if (we) chk("p1_wdata", mem_wdata, exp_wd);
            exp_splits++;
            @(negedge clk);
            chk("p2_stall", 32'(stall), 32'd0);
            chk("p2_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("p2_addr", mem_addr, a0 + 32'd4);
            chk("p2_we", 32'(mem_we), 32'(we2));
            if (we) chk("p2_wdata", mem_wdata, exp_wd);
            chk("p2_rdata", rsp_rdata, exp_rd);
        end else begin
            chk("ns_stall", 32'(stall), 32'd0);
            chk("ns_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("ns_we", 32'(mem_we), 32'(we1));
            chk("ns_rdata", rsp_rdata, exp_rd);
            if (legal) chk("ns_addr", mem_addr, a0);
            if (legal && we) chk("ns_wdata", mem_wdata, exp_wd);
        end
        rd_obs = rsp_rdata;
        @(posedge clk);
        #1;
        if (legal && we) begin
            for (int i = 0; i < sz; i++) ref_bytes[16'(addr + 32'(i))] = wd[8*i +: 8];
        end
        req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_cnt;
    logic [31:0] ra;
    logic [31:0] rdat;
    logic [2:0]  rf3;
    logic        rwe;

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        pre_en     = 1'b0;
        pre_idx    = 14'h0;
        pre_word   = 32'h0;
        exp_splits = 0;
        n_checks   = 0;
        n_pass     = 0;
        n_fail     = 0;

        // Preload low and high BRAM regions while reset holds the DUT quiet.
        for (int w = 0; w < 64; w++) begin
            if (w == 0)      preload(w, 32'h4433_2211);
            else if (w == 1) preload(w, 32'h8877_6655);
            else             preload(w, $urandom());
        end
        for (int w = 16320; w < 16384; w++) preload(w, $urandom());

        // Reset state with a split store presented.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0003;
        req_wdata  = 32'hDDCC_BBAA;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_cnt", split_cnt, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed accesses from the plan.
        do_req(1'b0, 3'b010, 32'h0, 32'h0, rd);
        chk("lw0", rd, 32'h4433_2211);
        do_req(1'b0, 3'b010, 32'h2, 32'h0, rd);
        chk("lw2", rd, 32'h6655_4433);
        do_req(1'b0, 3'b001, 32'h3, 32'h0, rd);
        chk("lh3", rd, 32'h0000_5544);
        do_req(1'b0, 3'b000, 32'h7, 32'h0, rd);
        chk("lb7", rd, 32'hFFFF_FF88);
        do_req(1'b0, 3'b100, 32'h7, 32'h0, rd);
        chk("lbu7", rd, 32'h0000_0088);
        do_req(1'b1, 3'b010, 32'h3, 32'hDDCC_BBAA, rd);
        chk("sw3_rdata", rd, 32'h0);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, rd);
        chk("rb_word0", rd, 32'hAA33_2211);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, rd);
        chk("rb_word4", rd, 32'h88DD_CCBB);

        // Illegal funct3 load and store.
        do_req(1'b0, 3'b011, 32'h5, 32'h0, rd);
        do_req(1'b1, 3'b110, 32'h6, 32'h1234_5678, rd);
        do_req(1'b1, 3'b111, 32'h1, 32'h1234_5678, rd);

        // Split load wrapping past the top of the address space.
        do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, rd);
        do_req(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hCAFE_BEEF, rd);
        do_req(1'b0, 3'b010, 32'h0000_0000, 32'h0, rd);

        // Abort a split store after its first half: first half stays, second never written.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0021;
        req_wdata  = 32'h0BAD_F00D;
        @(negedge clk);
        chk("ab_p1_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        exp_splits++;
        for (int i = 0; i < 3; i++) ref_bytes[16'(32'h21 + 32'(i))] = req_wdata[8*i +: 8];
        req_valid = 1'b0;
        #1;
        chk("ab_stall", 32'(stall), 32'd0);
        chk("ab_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ab_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, rd);
        do_req(1'b0, 3'b010, 32'h24, 32'h0, rd);

        // Reset during the first cycle of a split load.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0001;
        @(negedge clk);
        chk("rs_p1_stall", 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_splits = 0;
        chk("rs_stall", 32'(stall), 32'd0);
        chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rs_rdata", rsp_rdata, 32'h0);
        chk("rs_we", 32'(mem_we), 32'd0);
        chk("rs_addr", mem_addr, 32'h0);
        chk("rs_wdata", mem_wdata, 32'h0);
        chk("rs_cnt", split_cnt, 32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rs_idle_stall", 32'(stall), 32'd0);
        chk("rs_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rs_idle_we", 32'(mem_we), 32'd0);

        // Three split and two aligned accesses from a freshly reset counter.
        do_req(1'b0, 3'b010, 32'h1, 32'h0, rd);
        do_req(1'b0, 3'b010, 32'h2, 32'h0, rd);
        do_req(1'b0, 3'b001, 32'h7, 32'h0, rd);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, rd);
        do_req(1'b0, 3'b000, 32'h3, 32'h0, rd);
        #1;
`ifdef LSU_SPLIT_CNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        chk("cnt_3split", split_cnt, exp_cnt);

        // Random traffic against the byte-memory model.
        for (int it = 0; it < 300; it++) begin
            rwe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       rf3 = 3'b011;
                    1:       rf3 = 3'b110;
                    default: rf3 = 3'b111;
                endcase
            end else if (rwe) begin
                rf3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       rf3 = 3'b000;
                    1:       rf3 = 3'b001;
                    2:       rf3 = 3'b010;
                    3:       rf3 = 3'b100;
                    default: rf3 = 3'b101;
                endcase
            end
            ra = $urandom();
            if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFF00 | 16'($urandom_range(0, 255));
            else                           ra[15:0] = 16'($urandom_range(0, 240));
            rdat = $urandom();
            do_req(rwe, rf3, ra, rdat, rd);
        end

        #1;
`ifdef LSU_SPLIT_CNT_EN
        exp_cnt = 32'(exp_splits);
`else
        exp_cnt = 32'd0;
`endif
        chk("cnt_final", split_cnt, exp_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
Load/store alignment unit in the MEM stage, directly upstream of the data BRAM wrapper (byte-enabled synchronous write, combinational read, word-indexed by addr[15:2]).
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into BRAM byte enables, lane-rotated write data and word addresses.
- Extracts and sign/zero-extends load data.
- Accesses crossing a word boundary are split into two BRAM cycles, and the pipeline is stalled for one cycle.

Parameters:
ADDR_W, 32, width of request/memory address
CNT_W, 32, width of split-access counter (optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM-stage access request; held stable by pipeline while stall=1
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2)
stall  out  1  hold pipeline; request not yet complete
rsp_valid  out  1  access completes this cycle
rsp_rdata  out  32  extended load result (0 for stores)
mem_we  out  4  byte write enables to BRAM
mem_addr  out  ADDR_W  word-aligned address to BRAM (bits[1:0]=0)
mem_wdata  out  32  lane-rotated store data
mem_rdata  in  32  BRAM combinational read data
split_cnt  out  CNT_W  count of split accesses (optional feature)

Behaviour:
- Decode: size = 1/2/4 bytes from funct3[1:0]; unsigned = funct3[2]; k = req_addr[1:0].
- split = (size==2 && k==3) || (size==4 && k!=0).
- Illegal funct3 (011, 110, 111): no-op. mem_we=0, rsp_valid=1, rsp_rdata=0, stall=0.
- FSM states: IDLE, SECOND.
- IDLE, req_valid=0: mem_we=0, stall=0, rsp_valid=0.
- IDLE, non-split request:
  - mem_addr = {req_addr[ADDR_W-1:2],2'b00}.
  - Store: mem_we = lane mask (size mask << k).
  - rsp_valid=1 in the same cycle (zero added latency), stall=0.
- IDLE, split request:
  - First phase: mem_addr = word A; mem_we = (4'b1111<<k) & 4'hF for stores.
  - stall=1, rsp_valid=0.
  - On the clock edge: latch mem_rdata into lo_buf; go to SECOND.
- SECOND:
  - mem_addr = A+4, wrapping modulo 2^ADDR_W.
  - mem_we = lane mask >> (4-k) for stores.
  - stall=0, rsp_valid=1; return to IDLE on the next edge.
- Store data: mem_wdata = req_wdata rotated left by 8*k bits in both phases; the lane masks select the correct bytes.
- Load data:
  - Non-split: window = {32'b0, mem_rdata}.
  - Split: window = {mem_rdata, lo_buf}.
  - Shift the window right by 8*k, take the low size bytes, then sign-extend (signed) or zero-extend (unsigned).
- req_valid deasserted while in SECOND: abort to IDLE, no second access, rsp_valid=0. An already-written first store half is not rolled back.
- Reset: asynchronous. rst_n low forces state=IDLE and lo_buf=0. While rst_n is low: stall=0, rsp_valid=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset while in SECOND discards the pending half.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately after SECOND.

Optional Feature:
Macro LSU_SPLIT_CNT_EN.
- Defined: split_cnt increments by 1 on every clock edge that leaves IDLE for SECOND. It wraps at 2^CNT_W and resets to 0 on rst_n.
- Undefined: split_cnt is tied to 0 and no counter flops are built.

Test Plan:
Preload: word 0x0=0x44332211, word 0x4=0x88776655.
- LW 0x0 -> same cycle rsp_valid=1, rsp_rdata=0x44332211, stall=0.
- LW 0x2 -> cycle1 stall=1, mem_addr=0x0; cycle2 mem_addr=0x4, rsp_rdata=0x66554433.
- LH 0x3 -> split, rsp_rdata=0x00005544. LB 0x7 -> no split, rsp_rdata=0xFFFFFF88. LBU 0x7 -> rsp_rdata=0x00000088.
- SW 0x3, data 0xDDCCBBAA:
  - cycle1: mem_addr=0x0, mem_we=4'b1000, mem_wdata=0xAADDCCBB.
  - cycle2: mem_addr=0x4, mem_we=4'b0111.
  - Readback: word0=0xAA332211, word4=0x88DDCCBB.
- Assert rst_n=0 during the first cycle of split LW 0x1 -> outputs 0 immediately; after release, state IDLE, no second access.
- With LSU_SPLIT_CNT_EN: run 3 split + 2 aligned accesses -> split_cnt=3. Without the macro -> split_cnt=0.
